cnt_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the up/down counter and drives its load_en, load and down inputs. It accepts timed commands over a valid/ready handshake and buffers them in a small FIFO. It plays each command for a programmed number of cycles, back-to-back, and can end a command early when the counter reports rollover. It lets test and control logic script counter activity without cycle-accurate driving.

---
 rtl/cnt_cmd_seq_if.sv | 31 +++
 rtl/cnt_cmd_seq.sv | 166 ++++++++++++++++
 tb/tb_cnt_cmd_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_cmd_seq_if
// Description : Command handshake bundle for the counter command sequencer.
//               The producer holds cmd_valid and the command fields; the
//               sequencer answers with cmd_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_cmd_seq_if #(
  parameter int WIDTH = 4,
  parameter int LENW  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic             cmd_down;
  logic             cmd_stop_ro;
  logic [WIDTH-1:0] cmd_value;
  logic [LENW-1:0]  cmd_len;

  modport master (
    output cmd_valid, cmd_load, cmd_down, cmd_stop_ro, cmd_value, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_down, cmd_stop_ro, cmd_value, cmd_len,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/cnt_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : cnt_cmd_seq
// Description : Timed command sequencer driving an up/down counter's
//               load_en/load/down inputs. Commands are buffered in a small
//               FIFO and played back-to-back, each for max(len,1) cycles,
//               optionally cut short when the counter reports rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_cmd_seq #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  parameter  int LENW  = 8,
  localparam int LVLW  = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  cnt_cmd_seq_if.slave          cmd,
  input  wire logic             rollover_i,
  output logic                  load_en_o,
  output logic [WIDTH-1:0]      load_o,
  output logic                  down_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LVLW-1:0]       fifo_level_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int EW   = 3 + WIDTH + LENW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q;
  logic [PTRW-1:0]  rd_ptr_q;
  logic [LVLW-1:0]  level_q;

  // Sequencer state and registered outputs
  state_t           state_q;
  logic [LENW-1:0]  rem_q;
  logic             stop_ro_q;
  logic             load_en_q;
  logic [WIDTH-1:0] load_q;
  logic             down_q;
  logic             busy_q;
  logic             done_q;

  logic             full_w;
  logic             empty_w;
  logic             push_w;
  logic             pop_w;
  logic             cmd_end_w;
  logic [EW-1:0]    head_w;
  logic             head_load_w;
  logic             head_down_w;
  logic             head_stop_w;
  logic [WIDTH-1:0] head_value_w;
  logic [LENW-1:0]  head_len_w;
  logic [LENW-1:0]  len_d;

  assign full_w  = (level_q == LVLW'(DEPTH));
  assign empty_w = (level_q == '0);

  // Ready depends only on fullness, so a pop in the same cycle never opens it.
  assign cmd.cmd_ready = !full_w;
  assign push_w        = cmd.cmd_valid && !full_w;

  assign head_w       = mem_q[rd_ptr_q];
  assign head_load_w  = head_w[EW-1];
  assign head_down_w  = head_w[EW-2];
  assign head_stop_w  = head_w[EW-3];
  assign head_value_w = head_w[LENW +: WIDTH];
  assign head_len_w   = head_w[LENW-1:0];

  // A zero duration still plays for one cycle.
  assign len_d = (head_len_w == '0) ? LENW'(1) : head_len_w;

  // Decide whether the command being played finishes at this edge.
  always_comb begin
    cmd_end_w = 1'b0;
    case (state_q)
      S_LOAD:  cmd_end_w = (rem_q == LENW'(1));
      S_RUN:   cmd_end_w = (rem_q == LENW'(1)) || (stop_ro_q && rollover_i);
      default: cmd_end_w = 1'b0;
    endcase
  end

  // Pop when idle or at the ending edge so commands chain with no gap.
  assign pop_w = !empty_w && ((state_q == S_IDLE) || cmd_end_w);

  // Capture an accepted command into the FIFO array.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= {cmd.cmd_load, cmd.cmd_down, cmd.cmd_stop_ro,
                          cmd.cmd_value, cmd.cmd_len};
    end
  end

  // Track FIFO pointers and fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      case ({push_w, pop_w})
        2'b10:   level_q <= level_q + LVLW'(1);
        2'b01:   level_q <= level_q - LVLW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Play commands: pop, optional load cycle, count down duration, end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      stop_ro_q <= 1'b0;
      load_en_q <= 1'b0;
      load_q    <= '0;
      down_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= cmd_end_w;
      load_en_q <= 1'b0;
      if (pop_w) begin
        busy_q    <= 1'b1;
        down_q    <= head_down_w;
        stop_ro_q <= head_stop_w;
        rem_q     <= len_d;
        if (head_load_w) begin
          state_q   <= S_LOAD;
          load_en_q <= 1'b1;
          load_q    <= head_value_w;
        end else begin
          state_q <= S_RUN;
        end
      end else if (cmd_end_w) begin
        // Nothing queued: go quiet, keep down/load at their last values.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (state_q != S_IDLE) begin
        rem_q   <= rem_q - LENW'(1);
        state_q <= S_RUN;
      end
    end
  end

  assign load_en_o    = load_en_q;
  assign load_o       = load_q;
  assign down_o       = down_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fifo_level_o = level_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_cmd_seq
// Description : Self-checking bench for cnt_cmd_seq. A behavioural counter
//               closes the rollover loop; per-cycle expected outputs are
//               queued when commands are issued and popped each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_cmd_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LENW  = 8;
  localparam int LVLW  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rollover;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic             busy;
  logic             done;
  logic [LVLW-1:0]  fifo_level;
  logic [WIDTH-1:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic             le;
    logic [WIDTH-1:0] ld;
    logic             dn;
    logic             bz;
    logic             dp;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] exp_load;
  logic             exp_down;
  logic             pend_done;

  cnt_cmd_seq_if #(.WIDTH(WIDTH), .LENW(LENW)) cif ();

  cnt_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cif),
    .rollover_i   (rollover),
    .load_en_o    (load_en),
    .load_o       (load),
    .down_o       (down),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_level_o (fifo_level)
  );

  always #5 clk = ~clk;

  // Up/down counter the sequencer drives; counts every cycle unless loaded.
  always @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (load_en) cnt <= load;
    else if (down)    cnt <= cnt - 4'd1;
    else              cnt <= cnt + 4'd1;
  end
  assign rollover = &cnt;

  // Queue the output trace of one command lasting n cycles.
  task automatic expect_cmd(input logic ld, input logic [WIDTH-1:0] val,
                            input logic dn, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && ld) exp_load = val;
      exp_down = dn;
      e.le = (i == 0) && ld;
      e.ld = exp_load;
      e.dn = exp_down;
      e.bz = 1'b1;
      e.dp = (i == 0) ? pend_done : 1'b0;
      exp_q.push_back(e);
    end
    pend_done = 1'b1;
  endtask

  // Queue n idle cycles following whatever was queued before.
  task automatic expect_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.le = 1'b0;
      e.ld = exp_load;
      e.dn = exp_down;
      e.bz = 1'b0;
      e.dp = (i == 0) ? pend_done : 1'b0;
      exp_q.push_back(e);
    end
    pend_done = 1'b0;
  endtask

  // Compare n consecutive post-edge samples against the queued trace.
  task automatic run_check(input int n, input string name);
    exp_t e;
    exp_t a;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      a = '{le: load_en, ld: load, dn: down, bz: busy, dp: done};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s cycle %0d: no expected entry queued", name, i);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL %s cycle %0d: got le=%b ld=%h dn=%b busy=%b done=%b, want le=%b ld=%h dn=%b busy=%b done=%b",
                   name, i, a.le, a.ld, a.dn, a.bz, a.dp, e.le, e.ld, e.dn, e.bz, e.dp);
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s trailing: got %0d leftover entries, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Offer one command and wait (bounded) until it is accepted.
  task automatic push_one(input logic ld, input logic [WIDTH-1:0] val,
                          input logic dn, input logic st, input logic [LENW-1:0] len);
    bit ok = 0;
    cif.cmd_load    = ld;
    cif.cmd_value   = val;
    cif.cmd_down    = dn;
    cif.cmd_stop_ro = st;
    cif.cmd_len     = len;
    cif.cmd_valid   = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cif.cmd_ready;
      @(posedge clk);
      #1;
    end
    cif.cmd_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got ready=0 for 50 cycles, want ready=1");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_load  = '0;
    exp_down  = 1'b0;
    pend_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [8:0] a;
    logic [8:0] e;
    a = {load_en, load, down, busy, done, cif.cmd_ready};
    e = {1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s outputs: got le/ld/dn/busy/done/ready=%b, want %b", name, a, e);
    end
    n_vec++;
    if (fifo_level !== '0) begin
      n_err++;
      $display("FAIL %s level: got %0d, want 0", name, fifo_level);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_load_len3();
    push_one(1'b1, 4'hA, 1'b0, 1'b0, 8'd3);
    n_vec++;
    if (fifo_level !== 3'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load3_accept: got level=%0d busy=%b, want level=1 busy=0", fifo_level, busy);
    end
    expect_cmd(1'b1, 4'hA, 1'b0, 3);
    expect_idle(2);
    run_check(5, "load3");
  endtask

  task automatic test_stop_rollover();
    // D loaded, then D,E,F seen; F raises rollover and ends the command.
    push_one(1'b1, 4'hD, 1'b0, 1'b1, 8'd10);
    expect_cmd(1'b1, 4'hD, 1'b0, 4);
    expect_idle(3);
    run_check(7, "stop_ro_up");
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic [LVLW-1:0] exp_lvl [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
    logic            exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) expect_cmd(k == 2, 4'h5, k[0], 4);
    expect_idle(2);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          cif.cmd_load    = (k == 2);
          cif.cmd_value   = 4'h5;
          cif.cmd_down    = k[0];
          cif.cmd_stop_ro = 1'b0;
          cif.cmd_len     = 8'd4;
          cif.cmd_valid   = 1'b1;
          @(negedge clk);
          if (cif.cmd_ready) acc++;
          @(posedge clk);
          #1;
          n_vec++;
          if (fifo_level !== exp_lvl[k] || cif.cmd_ready !== exp_rdy[k]) begin
            n_err++;
            $display("FAIL b2b_level edge %0d: got level=%0d ready=%b, want level=%0d ready=%b",
                     k, fifo_level, cif.cmd_ready, exp_lvl[k], exp_rdy[k]);
          end
        end
        cif.cmd_valid = 1'b0;
      end
      begin
        @(posedge clk);
        run_check(22, "b2b");
      end
    join
    n_vec++;
    if (acc != 5) begin
      n_err++;
      $display("FAIL b2b_accepted: got %0d, want 5", acc);
    end
    n_vec++;
    if (fifo_level !== '0) begin
      n_err++;
      $display("FAIL b2b_drain: got level=%0d, want 0", fifo_level);
    end
  endtask

  task automatic test_len_zero();
    push_one(1'b0, 4'h0, 1'b1, 1'b0, 8'd0);
    expect_cmd(1'b0, 4'h0, 1'b1, 1);
    expect_idle(2);
    run_check(3, "len0");
  endtask

  task automatic test_reset_mid();
    push_one(1'b0, 4'h0, 1'b1, 1'b0, 8'd5);
    expect_cmd(1'b0, 4'h0, 1'b1, 2);
    pend_done = 1'b0;
    fork
      push_one(1'b1, 4'h3, 1'b0, 1'b0, 8'd2);
      run_check(2, "mid_pre");
    join
    n_vec++;
    if (fifo_level !== 3'd1) begin
      n_err++;
      $display("FAIL mid_queued: got level=%0d, want 1", fifo_level);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_load  = '0;
    exp_down  = 1'b0;
    pend_done = 1'b0;
    expect_idle(4);
    run_check(4, "mid_after");
  endtask

  task automatic test_stop_rollover_down();
    // 0 loaded, next cycle wraps to F which ends the command.
    push_one(1'b1, 4'h0, 1'b1, 1'b1, 8'd4);
    expect_cmd(1'b1, 4'h0, 1'b1, 3);
    expect_idle(2);
    run_check(5, "stop_ro_down");
  endtask

  initial begin
    cif.cmd_valid   = 1'b0;
    cif.cmd_load    = 1'b0;
    cif.cmd_down    = 1'b0;
    cif.cmd_stop_ro = 1'b0;
    cif.cmd_value   = '0;
    cif.cmd_len     = '0;
    exp_load        = '0;
    exp_down        = 1'b0;
    pend_done       = 1'b0;
    test_reset();
    test_load_len3();
    test_stop_rollover();
    test_back_to_back();
    test_len_zero();
    test_reset_mid();
    test_stop_rollover_down();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
